segasys1_ioctl: RTL and testbench

SEGASYS1_IOCTL -- requirements
Module: segasys1_ioctl

---
 rtl/segasys1_ioctl_if.sv | 12 +
 rtl/segasys1_ioctl.sv | 111 +++++++++++
 tb/tb_segasys1_ioctl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/segasys1_ioctl_if.sv
// segasys1_ioctl_if: CPU I/O bus between the Z80-side master and the I/O controller.
interface segasys1_ioctl_if;
    logic [7:0] IOAD;
    logic       IORQ;
    logic       IOWR;
    logic       IORD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       DV;
    modport master (output IOAD, IORQ, IOWR, IORD, DI, input DO, DV);
    modport slave  (input IOAD, IORQ, IOWR, IORD, DI, output DO, DV);
endinterface

// File: rtl/segasys1_ioctl.sv
// segasys1_ioctl: CPU clock enable, port reads, video-mode latch and sound-command queue.
// Optional SEGASYS1_IOCTL_SQSTAT_EN adds a queue status read at 0x1C that clears the overflow flag.
module segasys1_ioctl #(
    parameter int NPORT    = 5,
    parameter int SQ_DEPTH = 4,
    parameter int CEDIV    = 16
) (
    input  logic                 CLK48M,
    input  logic                 RESET,
    output logic                 CPUCE,
    segasys1_ioctl_if.slave      bus,
    input  logic [8*NPORT-1:0]   INP,
    output logic [7:0]           VIDMD,
    output logic                 SNDRQ,
    output logic [7:0]           SNDNO,
    input  logic                 SNDACK,
    output logic                 SQFULL
);
    localparam int CW   = $clog2(CEDIV);
    localparam int PW   = $clog2(SQ_DEPTH);
    localparam int CNTW = PW + 1;

    logic [CW-1:0]   ce_cnt;
    logic [PW-1:0]   rp, wp;
    logic [CNTW-1:0] count;
    logic [7:0]      mem [SQ_DEPTH];
    logic            ovf, wr_prev, wr_act, rd_act, wr_acc;
    logic            vid_sel, snd_sel, push, pop, do_push, ovf_clr;
    logic            port_hit;
    logic [7:0]      port_val;

    assign CPUCE = ce_cnt == CW'(CEDIV - 1);

    always_ff @(posedge CLK48M or posedge RESET)
        if (RESET) ce_cnt <= '0;
        else       ce_cnt <= CPUCE ? '0 : ce_cnt + CW'(1);

    assign wr_act  = bus.IORQ & bus.IOWR;
    assign rd_act  = bus.IORQ & bus.IORD;
    assign wr_acc  = CPUCE & wr_act & ~wr_prev;
    assign vid_sel = (bus.IOAD == 8'h15) | (bus.IOAD == 8'h19);
    assign snd_sel = (bus.IOAD == 8'h14) | (bus.IOAD == 8'h18);
    assign push    = wr_acc & snd_sel;
    assign pop     = SNDACK & (count != '0);
    assign SQFULL  = count == CNTW'(SQ_DEPTH);
    // A pop frees the slot in the same edge, so a push into a full queue still lands.
    assign do_push = push & (~SQFULL | pop);
    assign SNDRQ   = count != '0;
    assign SNDNO   = SNDRQ ? mem[rp] : 8'h00;

`ifdef SEGASYS1_IOCTL_SQSTAT_EN
    logic rd_prev, stat_sel;
    assign stat_sel = bus.IOAD == 8'h1C;
    assign ovf_clr  = CPUCE & rd_act & ~rd_prev & stat_sel;

    always_ff @(posedge CLK48M or posedge RESET)
        if (RESET)      rd_prev <= 1'b0;
        else if (CPUCE) rd_prev <= rd_act;
`else
    assign ovf_clr = 1'b0;
`endif

    always_ff @(posedge CLK48M or posedge RESET)
        if (RESET) begin
            wr_prev <= 1'b0;
            VIDMD   <= 8'h00;
            rp      <= '0;
            wp      <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            if (CPUCE) wr_prev <= wr_act;
            if (wr_acc & vid_sel) VIDMD <= bus.DI;
            if (do_push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            count <= count + CNTW'(do_push) - CNTW'(pop);
            ovf   <= (ovf & ~ovf_clr) | (push & SQFULL & ~pop);
        end

    always_ff @(posedge CLK48M)
        if (do_push) mem[wp] <= bus.DI;

    always_comb begin
        port_hit = 1'b0;
        port_val = 8'hFF;
        for (int i = 0; i < NPORT; i++)
            if (bus.IOAD[5:2] == 4'(i)) begin
                port_hit = 1'b1;
                port_val = INP[8*i +: 8];
            end
    end

    always_comb begin
        bus.DV = 1'b0;
        bus.DO = 8'hFF;
        if (rd_act & vid_sel) begin
            bus.DV = 1'b1;
            bus.DO = VIDMD;
        end
`ifdef SEGASYS1_IOCTL_SQSTAT_EN
        else if (rd_act & stat_sel) begin
            bus.DV = 1'b1;
            bus.DO = {ovf, 3'b000, 4'(count)};
        end
`endif
        else if (rd_act & port_hit) begin
            bus.DV = 1'b1;
            bus.DO = port_val;
        end
    end
endmodule

// File: tb/tb_segasys1_ioctl.sv
// tb_segasys1_ioctl: directed checks of clock enable, write edge rule, sound queue, reads and reset.
module tb_segasys1_ioctl;
    logic        CLK48M = 1'b0;
    logic        RESET  = 1'b1;
    logic        CPUCE;
    logic [39:0] INP;
    logic [7:0]  VIDMD, SNDNO;
    logic        SNDRQ, SNDACK, SQFULL;
    int          tests = 0, fails = 0;

    segasys1_ioctl_if bus ();

    segasys1_ioctl #(.NPORT(5), .SQ_DEPTH(4), .CEDIV(16)) dut (
        .CLK48M(CLK48M), .RESET(RESET), .CPUCE(CPUCE), .bus(bus), .INP(INP),
        .VIDMD(VIDMD), .SNDRQ(SNDRQ), .SNDNO(SNDNO), .SNDACK(SNDACK), .SQFULL(SQFULL)
    );

    always #5 CLK48M = ~CLK48M;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data, input int periods);
        bus.IOAD = addr; bus.DI = data; bus.IORQ = 1'b1; bus.IOWR = 1'b1;
        repeat (16 * periods) @(negedge CLK48M);
        bus.IORQ = 1'b0; bus.IOWR = 1'b0;
        repeat (16) @(negedge CLK48M);
    endtask

    task automatic io_read(input string tag, input logic [7:0] addr, input logic dv, input logic [7:0] dat);
        bus.IOAD = addr; bus.IORQ = 1'b1; bus.IORD = 1'b1;
        #1;
        chk({tag, ".dv"}, {7'b0, bus.DV}, {7'b0, dv});
        chk({tag, ".do"}, bus.DO, dat);
        repeat (16) @(negedge CLK48M);
        bus.IORQ = 1'b0; bus.IORD = 1'b0;
        repeat (16) @(negedge CLK48M);
    endtask

    task automatic ack();
        SNDACK = 1'b1;
        @(negedge CLK48M);
        SNDACK = 1'b0;
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, SNDNO, exp);
        ack();
    endtask

    // Write strobe raised, then SNDACK placed on exactly the clock that accepts the write.
    task automatic push_with_ack(input logic [7:0] data);
        int b;
        bus.IOAD = 8'h14; bus.DI = data; bus.IORQ = 1'b1; bus.IOWR = 1'b1;
        for (b = 0; b < 40 && !CPUCE; b++) @(negedge CLK48M);
        if (!CPUCE) chk("ce_wait_timeout", 8'h00, 8'h01);
        ack();
        bus.IORQ = 1'b0; bus.IOWR = 1'b0;
        repeat (16) @(negedge CLK48M);
    endtask

    initial begin
        bus.IOAD = 8'h00; bus.DI = 8'h00; bus.IORQ = 1'b0; bus.IOWR = 1'b0; bus.IORD = 1'b0;
        SNDACK = 1'b0;
        INP = {8'h44, 8'h33, 8'hA5, 8'h11, 8'h00};
        repeat (3) @(negedge CLK48M);
        chk("rst.cpuce", {7'b0, CPUCE}, 8'h00);
        chk("rst.sndrq", {7'b0, SNDRQ}, 8'h00);
        chk("rst.sndno", SNDNO, 8'h00);
        chk("rst.sqfull", {7'b0, SQFULL}, 8'h00);
        chk("rst.vidmd", VIDMD, 8'h00);
        chk("idle.dv", {7'b0, bus.DV}, 8'h00);
        chk("idle.do", bus.DO, 8'hFF);

        RESET = 1'b0;
        for (int n = 1; n <= 48; n++) begin
            chk($sformatf("ce.cyc%0d", n), {7'b0, CPUCE}, (n % 16 == 0) ? 8'h01 : 8'h00);
            @(negedge CLK48M);
        end

        io_write(8'h18, 8'h5A, 3);
        chk("held.sndrq", {7'b0, SNDRQ}, 8'h01);
        chk("held.sndno", SNDNO, 8'h5A);
        ack();
        chk("held.once", {7'b0, SNDRQ}, 8'h00);
        chk("held.empty_no", SNDNO, 8'h00);

        for (int i = 1; i <= 5; i++) io_write(8'h14, 8'(i), 1);
        chk("full.sqfull", {7'b0, SQFULL}, 8'h01);
`ifdef SEGASYS1_IOCTL_SQSTAT_EN
        io_read("stat1", 8'h1C, 1'b1, 8'h84);
`else
        io_read("stat_off", 8'h1C, 1'b0, 8'hFF);
`endif
        for (int i = 1; i <= 4; i++) pop_chk($sformatf("full.pop%0d", i), 8'(i));
        chk("full.drained", {7'b0, SNDRQ}, 8'h00);
`ifdef SEGASYS1_IOCTL_SQSTAT_EN
        io_read("stat2", 8'h1C, 1'b1, 8'h00);
`endif

        ack();
        chk("empty_ack.sndrq", {7'b0, SNDRQ}, 8'h00);
        push_with_ack(8'h42);
        chk("empty_pp.sndrq", {7'b0, SNDRQ}, 8'h01);
        chk("empty_pp.sndno", SNDNO, 8'h42);
        ack();
        chk("empty_pp.count1", {7'b0, SNDRQ}, 8'h00);

        for (int i = 1; i <= 4; i++) io_write(8'h14, 8'(8'h10 + i), 1);
        push_with_ack(8'h77);
        chk("fullpp.sqfull", {7'b0, SQFULL}, 8'h01);
        pop_chk("fullpp.pop1", 8'h12);
        pop_chk("fullpp.pop2", 8'h13);
        pop_chk("fullpp.pop3", 8'h14);
        pop_chk("fullpp.pop4", 8'h77);
        chk("fullpp.drained", {7'b0, SNDRQ}, 8'h00);

        io_read("in08", 8'h08, 1'b1, 8'hA5);
        io_read("in00", 8'h00, 1'b1, 8'h00);
        io_read("in10", 8'h10, 1'b1, 8'h44);
        io_write(8'h19, 8'h3C, 1);
        chk("vidmd", VIDMD, 8'h3C);
        io_read("in15", 8'h15, 1'b1, 8'h3C);
        io_read("in20", 8'h20, 1'b0, 8'hFF);
        io_write(8'h15, 8'h96, 2);
        io_read("in19", 8'h19, 1'b1, 8'h96);

        for (int i = 0; i < 3; i++) io_write(8'h18, 8'(8'h21 + i), 1);
        chk("pre_rst.sndno", SNDNO, 8'h21);
        @(posedge CLK48M);
        #2 RESET = 1'b1;
        #1;
        chk("async.sndrq", {7'b0, SNDRQ}, 8'h00);
        chk("async.vidmd", VIDMD, 8'h00);
        chk("async.sndno", SNDNO, 8'h00);
        chk("async.sqfull", {7'b0, SQFULL}, 8'h00);
        @(negedge CLK48M);
        RESET = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            chk($sformatf("ce2.cyc%0d", n), {7'b0, CPUCE}, (n == 16) ? 8'h01 : 8'h00);
            @(negedge CLK48M);
        end
        chk("post_rst.sndrq", {7'b0, SNDRQ}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
